// File: rtl/psum_acc_pkg.sv
// Shared defaults for the partial-sum accumulator: word width, row length and
// the number of MAC contributions that complete one row.
package psum_acc_pkg;

   localparam int PSUM_WIDTH_DEF   = 24;
   localparam int LENROW           = 16;
   localparam int MAC_PER_PSUM_DEF = 9;

   // Contribution counter width; must hold MAC_PER_PSUM.
   localparam int CNT_W = 4;

endpackage : psum_acc_pkg

// File: rtl/psum_sat_add.sv
// Combinational signed saturating adder: a + b computed one bit wider, then
// clamped to the representable range of W bits.
module psum_sat_add
   import psum_acc_pkg::*;
#(
   parameter int W = PSUM_WIDTH_DEF
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o
);

   localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   logic [W:0] full;

   always_comb begin
      full  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
      sum_o = full[W-1:0];
      // Sign bit and the bit below it disagree only on overflow.
      if (full[W] != full[W-1]) begin
         sum_o = full[W] ? MIN_V : MAX_V;
      end
   end

endmodule : psum_sat_add

// File: rtl/psum_acc.sv
// One partial-sum channel: accumulates MAC contributions into a row buffer and
// streams the finished row to the global buffer with valid/ready handshakes.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no row in progress; empty reported to the arbiter
//   ACC   | accepting MAC words, overwrite on first contribution, else add
//   OUT   | streaming row words buf[ra] downstream; MAC side stalled
module psum_acc
   import psum_acc_pkg::*;
#(
   parameter int PSUM_WIDTH   = PSUM_WIDTH_DEF,
   parameter int LENPSUM      = LENROW,
   parameter int MAC_PER_PSUM = MAC_PER_PSUM_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  PEBARB_Sta,
   input  logic                  ARBPSUM_fnh,
   input  logic                  MACPSUM_Val,
   input  logic [PSUM_WIDTH-1:0] MACPSUM_Dat,
   input  logic                  MACPSUM_Last,
   output logic                  PSUMMAC_Rdy,
   output logic                  PSUMARB_empty,
   output logic                  PSUMGLB_Val,
   output logic [PSUM_WIDTH-1:0] PSUMGLB_Dat,
   input  logic                  GLBPSUM_Rdy
);

   localparam int AW = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
   localparam logic [AW-1:0]    A_LAST  = AW'(LENPSUM - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAC_PER_PSUM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [AW-1:0]         wa_q, wa_d;
   logic [AW-1:0]         ra_q, ra_d;
   logic [PSUM_WIDTH-1:0] row_q [LENPSUM];
   logic [PSUM_WIDTH-1:0] row_d [LENPSUM];

   logic                  mac_acc;
   logic                  glb_acc;
   logic [PSUM_WIDTH-1:0] sat_sum;

   assign PSUMMAC_Rdy   = (state_q != OUT);
   assign PSUMGLB_Val   = (state_q == OUT);
   assign PSUMARB_empty = (state_q == IDLE);
   assign PSUMGLB_Dat   = row_q[ra_q];

   assign mac_acc = MACPSUM_Val && PSUMMAC_Rdy;
   assign glb_acc = PSUMGLB_Val && GLBPSUM_Rdy;

   // Only buf[wa] is touched per cycle, so a single adder serves the whole row.
   psum_sat_add #(
      .W (PSUM_WIDTH)
   ) u_sat_add (
      .a_i   (row_q[wa_q]),
      .b_i   (MACPSUM_Dat),
      .sum_o (sat_sum)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wa_d    = wa_q;
      ra_d    = ra_q;
      row_d   = row_q;

      if (PEBARB_Sta) begin
         state_d = IDLE;
         cnt_d   = '0;
         wa_d    = '0;
         ra_d    = '0;
      end else begin
         if (mac_acc) begin
            row_d[wa_q] = (cnt_q == '0) ? MACPSUM_Dat : sat_sum;
            if (MACPSUM_Last) begin
               wa_d = '0;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               wa_d = (wa_q == A_LAST) ? '0 : wa_q + AW'(1);
            end
         end

         case (state_q)
            IDLE: begin
               if (mac_acc) begin
                  state_d = ACC;
               end
            end
            ACC: begin
               if ((cnt_q == CNT_MAX) && ARBPSUM_fnh) begin
                  state_d = OUT;
               end
            end
            OUT: begin
               if (glb_acc) begin
                  if (ra_q == A_LAST) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     wa_d    = '0;
                     ra_d    = '0;
                  end else begin
                     ra_d = ra_q + AW'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wa_q    <= '0;
         ra_q    <= '0;
         for (int i = 0; i < LENPSUM; i++) begin
            row_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wa_q    <= wa_d;
         ra_q    <= ra_d;
         row_q   <= row_d;
      end
   end

endmodule : psum_acc

// File: tb/tb_psum_acc.sv
// Randomized bench for psum_acc: rows are built from per-contribution word
// lists and the expected row is the saturating sum of those lists.
module tb_psum_acc;

   localparam int W   = 24;
   localparam int LEN = 16;
   localparam int NC  = 9;

   logic         clk;
   logic         rst_n;
   logic         PEBARB_Sta;
   logic         ARBPSUM_fnh;
   logic         MACPSUM_Val;
   logic [W-1:0] MACPSUM_Dat;
   logic         MACPSUM_Last;
   logic         PSUMMAC_Rdy;
   logic         PSUMARB_empty;
   logic         PSUMGLB_Val;
   logic [W-1:0] PSUMGLB_Dat;
   logic         GLBPSUM_Rdy;

   int n_chk = 0;
   int n_err = 0;

   logic [W-1:0] exp_row [LEN];

   psum_acc #(
      .PSUM_WIDTH   (W),
      .LENPSUM      (LEN),
      .MAC_PER_PSUM (NC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PEBARB_Sta    (PEBARB_Sta),
      .ARBPSUM_fnh   (ARBPSUM_fnh),
      .MACPSUM_Val   (MACPSUM_Val),
      .MACPSUM_Dat   (MACPSUM_Dat),
      .MACPSUM_Last  (MACPSUM_Last),
      .PSUMMAC_Rdy   (PSUMMAC_Rdy),
      .PSUMARB_empty (PSUMARB_empty),
      .PSUMGLB_Val   (PSUMGLB_Val),
      .PSUMGLB_Dat   (PSUMGLB_Dat),
      .GLBPSUM_Rdy   (GLBPSUM_Rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > 64'sd8388607)  return 24'h7FFFFF;
      if (s < -64'sd8388608) return 24'h800000;
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] pick_word(input int rnd, input logic [W-1:0] cval);
      if (rnd == 0) return cval;
      if ($urandom_range(0, 3) == 0) return W'($urandom);
      return W'($urandom_range(0, 2000) - 1000);
   endfunction

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic mac_word(input logic [W-1:0] w, input bit last, input int gaps);
      int budget;
      budget = 0;
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
         MACPSUM_Val = 1'b0;
         @(negedge clk);
      end
      MACPSUM_Val  = 1'b1;
      MACPSUM_Dat  = w;
      MACPSUM_Last = last;
      while (!PSUMMAC_Rdy && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!PSUMMAC_Rdy) chk("mac_rdy_timeout", 32'(PSUMMAC_Rdy), 32'd1);
      @(negedge clk);
      MACPSUM_Val  = 1'b0;
      MACPSUM_Last = 1'b0;
   endtask

   // Contribution k of the current row, words start..len-1 (Last on len-1).
   task automatic send_contrib(input int k, input int len, input int start,
                               input int rnd, input logic [W-1:0] cval, input int gaps);
      logic [W-1:0] w;
      for (int i = start; i < len; i++) begin
         w = pick_word(rnd, cval);
         mac_word(w, (i == len - 1), gaps);
         exp_row[i] = (k == 0) ? w : sat_add(exp_row[i], w);
      end
   endtask

   task automatic send_row(input int rnd, input logic [W-1:0] cval, input int gaps, input int trunc);
      int len;
      for (int k = 0; k < NC; k++) begin
         len = (trunc != 0 && k > 0) ? int'($urandom_range(1, LEN)) : LEN;
         send_contrib(k, len, 0, rnd, cval, gaps);
      end
   endtask

   // mode 0: Rdy=1, mode 1: toggle every cycle, mode 2: random.
   task automatic drain(input int mode, input int hold_mac, input logic [W-1:0] hw, input int nwords);
      int  idx;
      int  budget;
      bit  r;
      bit  tog;
      idx    = 0;
      budget = 0;
      tog    = 1'b0;
      while (idx < nwords && budget < 600) begin
         tog = ~tog;
         r   = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         GLBPSUM_Rdy = r;
         if (PSUMGLB_Val) begin
            chk("out_word", 32'(PSUMGLB_Dat), 32'(exp_row[idx]));
            if (r) begin
               if (idx == LEN - 1 && hold_mac != 0) begin
                  MACPSUM_Val  = 1'b1;
                  MACPSUM_Dat  = hw;
                  MACPSUM_Last = 1'b0;
                  chk("mac_rdy_final_out", 32'(PSUMMAC_Rdy), 32'd0);
               end
               idx++;
            end
         end
         @(negedge clk);
         budget++;
      end
      if (idx < nwords) chk("drain_timeout", 32'(idx), 32'(nwords));
      if (nwords == LEN) begin
         chk("empty_after_row", 32'(PSUMARB_empty), 32'd1);
         chk("val_after_row", 32'(PSUMGLB_Val), 32'd0);
      end
   endtask

   initial begin
      logic [W-1:0] hw;
      rst_n        = 1'b0;
      PEBARB_Sta   = 1'b0;
      ARBPSUM_fnh  = 1'b1;
      MACPSUM_Val  = 1'b0;
      MACPSUM_Dat  = '0;
      MACPSUM_Last = 1'b0;
      GLBPSUM_Rdy  = 1'b1;
      for (int i = 0; i < LEN; i++) exp_row[i] = '0;

      repeat (2) @(negedge clk);
      chk("rst_empty", 32'(PSUMARB_empty), 32'd1);
      chk("rst_mac_rdy", 32'(PSUMMAC_Rdy), 32'd1);
      chk("rst_glb_val", 32'(PSUMGLB_Val), 32'd0);
      chk("rst_glb_dat", 32'(PSUMGLB_Dat), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All-ones row, then the same row under alternating back-pressure.
      send_row(0, 24'd1, 0, 0);
      drain(0, 0, '0, LEN);
      send_row(0, 24'd1, 1, 0);
      drain(1, 0, '0, LEN);

      // Saturation at both ends of the range.
      send_row(0, 24'h3FFFFF, 0, 0);
      drain(0, 0, '0, LEN);
      send_row(0, 24'hC00000, 0, 0);
      drain(1, 0, '0, LEN);

      // Count reaches 9 with fnh low: no output; extra Last still accumulates.
      ARBPSUM_fnh = 1'b0;
      send_row(1, '0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fnh_low_val", 32'(PSUMGLB_Val), 32'd0);
         chk("fnh_low_empty", 32'(PSUMARB_empty), 32'd0);
      end
      send_contrib(NC, LEN, 0, 1, '0, 0);
      chk("fnh_low_val_extra", 32'(PSUMGLB_Val), 32'd0);
      ARBPSUM_fnh = 1'b1;
      @(negedge clk);
      chk("fnh_rise_val", 32'(PSUMGLB_Val), 32'd1);
      drain(2, 0, '0, LEN);

      // MAC word held across the final output handshake.
      send_row(1, '0, 1, 0);
      hw = W'($urandom);
      drain(0, 1, hw, LEN);
      chk("held_word_rdy", 32'(PSUMMAC_Rdy), 32'd1);
      @(negedge clk);
      MACPSUM_Val = 1'b0;
      chk("held_word_empty_drop", 32'(PSUMARB_empty), 32'd0);
      exp_row[0] = hw;
      send_contrib(0, LEN, 1, 1, '0, 1);
      for (int k = 1; k < NC; k++) send_contrib(k, LEN, 0, 1, '0, 1);
      drain(2, 0, '0, LEN);

      // Reset in the middle of the output phase.
      send_row(1, '0, 0, 0);
      drain(0, 0, '0, 5);
      rst_n = 1'b0;
      #1;
      chk("midout_rst_val", 32'(PSUMGLB_Val), 32'd0);
      chk("midout_rst_empty", 32'(PSUMARB_empty), 32'd1);
      chk("midout_rst_dat", 32'(PSUMGLB_Dat), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < LEN; i++) exp_row[i] = '0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_val", 32'(PSUMGLB_Val), 32'd0);
      end
      send_row(1, '0, 1, 1);
      drain(2, 0, '0, LEN);

      // Block start mid-accumulation discards the partial row and its count.
      for (int k = 0; k < 4; k++) send_contrib(k, LEN, 0, 1, '0, 0);
      PEBARB_Sta = 1'b1;
      @(negedge clk);
      PEBARB_Sta = 1'b0;
      chk("sta_empty", 32'(PSUMARB_empty), 32'd1);
      send_row(1, '0, 1, 0);
      drain(2, 0, '0, LEN);

      // Random rows with truncated contributions and random back-pressure.
      for (int n = 0; n < 3; n++) begin
         send_row(1, '0, 1, 1);
         drain(2, 0, '0, LEN);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule : tb_psum_acc

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 Parameter PSUM_WIDTH, default 24, signed partial-sum word width.
REQ-002 Parameter LENPSUM, default `LENROW, words per output row.
REQ-003 Parameter MAC_PER_PSUM, default 9, contributions that complete one row.
REQ-004 Port clk, input, 1: the single clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port PEBARB_Sta, input, 1: block start; synchronously returns the block to IDLE.
REQ-007 Port ARBPSUM_fnh, input, 1: arbiter has assigned all contributions for this channel.
REQ-008 Port MACPSUM_Val, input, 1: MAC word valid.
REQ-009 Port MACPSUM_Dat, input, PSUM_WIDTH: signed MAC partial-sum word.
REQ-010 Port MACPSUM_Last, input, 1: last word of one MAC contribution.
REQ-011 Port PSUMMAC_Rdy, output, 1: word accepted when Val&&Rdy.
REQ-012 Port PSUMARB_empty, output, 1: level, high when state==IDLE.
REQ-013 Port PSUMGLB_Val, output, 1: output word valid.
REQ-014 Port PSUMGLB_Dat, output, PSUM_WIDTH: accumulated row word.
REQ-015 Port GLBPSUM_Rdy, input, 1: downstream accepts when Val&&Rdy.

Function
REQ-016 FSM states: IDLE, ACC, OUT.
REQ-017 IDLE->ACC on an accepted MAC word; ACC->OUT when contribution count==MAC_PER_PSUM and ARBPSUM_fnh==1; OUT->IDLE on acceptance of word LENPSUM-1.
REQ-018 PSUMMAC_Rdy = (state!=OUT); PSUMGLB_Val = (state==OUT).
REQ-019 Write address wa increments per accepted MAC word; resets to 0 on accepted Last (an early Last truncates the contribution; remaining words keep their prior value).
REQ-020 Contribution counter (4 bits) increments on each accepted Last; saturates at MAC_PER_PSUM; extra Last words still accumulate but do not increment.
REQ-021 While count==0, an accepted word overwrites buf[wa]; otherwise buf[wa] <= sat(buf[wa]+MACPSUM_Dat).
REQ-022 sat(): signed PSUM_WIDTH+1-bit sum clamped to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
REQ-023 In OUT, PSUMGLB_Dat = buf[ra], combinational from the register array; ra increments on each accepted output word; no words are skipped or repeated under back-pressure.
REQ-024 OUT->IDLE clears count, wa and ra in the same cycle; a MAC word valid in that cycle is not accepted (Rdy low) and is accepted in the following IDLE cycle.
REQ-025 PEBARB_Sta has priority over all other events: next state IDLE, count/wa/ra cleared, buffer contents don't-care.
REQ-026 PSUMARB_empty rises in the cycle after the final output handshake.

Reset
REQ-027 On rst_n low: state=IDLE, count=0, wa=0, ra=0; PSUMARB_empty=1, PSUMMAC_Rdy=1, PSUMGLB_Val=0, PSUMGLB_Dat=0 (buffer reset to 0).
REQ-028 Reset mid-ACC or mid-OUT discards the row; no output word is issued after deassertion until a new row completes.

Structure
REQ-029 PSUM_WIDTH, LENPSUM and MAC_PER_PSUM defaults live in the shared dw_params include; the FSM state encoding is local.
REQ-030 One sub-module, psum_sat_add (combinational saturating adder); the parent instantiates 9 psum_acc channels.

Verification
REQ-031 9 contributions of LENPSUM words, each word=1, fnh=1, GLB Rdy=1 -> 16 output words each =9, then empty=1.
REQ-032 Back-pressure: GLB Rdy toggles 1/0 each cycle -> the same 16 words in order, each held stable while Rdy=0.
REQ-033 Saturation: 9 contributions of word 0x3FFFFF -> output 0x7FFFFF; of 0xC00000 -> 0x800000.
REQ-034 count==9 with fnh=0 -> stays in ACC, no GLB Val; fnh rises -> Val high the next cycle.
REQ-035 MAC Val held high across the final output handshake -> not accepted that cycle; accepted one cycle later as the first word of a new row, with empty=1 only in that cycle.
REQ-036 rst_n pulsed mid-OUT after 5 words -> Val=0 and empty=1 immediately; next full row outputs correct sums.
